// File: rtl/btn_pkg.sv
// Shared types and width helpers for the pushbutton debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } btn_state_e;

  localparam int unsigned SyncStages = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, tick-qualified stability FSM and edge pulses.
// Auto-repeat on held presses is built only when BTN_DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 16
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 64,
  parameter int unsigned REPEAT_RATE  = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = cnt_w(STABLE_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  sync;
  btn_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  rpt_fire;

  assign sync_d = {sync_q[SyncStages-2:0], raw_i};
  assign sync   = sync_q[SyncStages-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!sync) begin
          state_d = S_LOW;
        end else if (tick_i) begin
          if (cnt_q == CntMax) begin
            state_d = S_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end else if (rpt_fire) begin
          rise_d = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (sync) begin
          state_d = S_HIGH;
        end else if (tick_i) begin
          if (cnt_q == CntMax) begin
            state_d = S_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int unsigned RptW = cnt_w((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [RptW-1:0] RptDelayMax = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptRateMax  = RptW'(REPEAT_RATE - 1);

  logic [RptW-1:0] rpt_q, rpt_d;
  logic            rpt_first_q, rpt_first_d;

  // Held-high tick count; first period is REPEAT_DELAY, later ones REPEAT_RATE.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if ((state_q != S_HIGH) || !sync) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (tick_i) begin
      if (rpt_q == (rpt_first_q ? RptDelayMax : RptRateMax)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel pushbutton debouncer with a shared tick prescaler.
// Define BTN_DEBOUNCE_REPEAT_EN to add auto-repeat rise pulses on held inputs.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 2,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 16,
  parameter int unsigned REPEAT_DELAY = 64,
  parameter int unsigned REPEAT_RATE  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic               tick
);

  localparam int unsigned PreW = cnt_w(TICK_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  if ((TICK_DIV < 2) || (STABLE_TICKS < 2) || (REPEAT_DELAY == 0) || (REPEAT_RATE == 0))
  begin : g_param_err
    $error("btn_debounce: TICK_DIV/STABLE_TICKS must be >= 2, repeat periods nonzero");
  end

  logic [PreW-1:0] pre_q, pre_d;

  assign pre_d = (pre_q == PreMax) ? '0 : pre_q + 1'b1;
  assign tick  = (pre_q == PreMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .rise_o (btn_rise[i]),
      .fall_o (btn_fall[i])
    );
  end

endmodule
